tdc_cal_ctrl: RTL and testbench

Gain-calibration sequencer for the delay-line TDC. On start it drives a calibration-enable line so the TDC sees a known reference/feedback time offset. It then runs a successive-approximation (SAR) search over the delay-line trim code, averaging TDC output codes at each step. It holds the final trim until the next calibration, and it sits between the TDC output and the delay-line trim input in the PLL phase-detector path.

---
 rtl/tdc_pkg.sv | 32 +++
 rtl/tdc_accum.sv | 40 ++++
 rtl/tdc_cal_ctrl.sv | 146 ++++++++++++++
 tb/tb_tdc_cal_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC gain-calibration sequencer.
// Holds the code/trim/sum widths, the FSM state encoding, the mid-scale trim
// value and the decision threshold (Target scaled by the averaging length).
package tdc_pkg;

    localparam int unsigned NBIT      = 4;
    localparam int unsigned NTRIM     = 6;
    localparam int unsigned NAVG_LOG2 = 4;
    localparam int unsigned TSETTLE   = 8;
    localparam int          TARGET    = 0;

    localparam int unsigned NSUM = NBIT + NAVG_LOG2;
    localparam int unsigned NIDX = $clog2(NTRIM);
    localparam int unsigned NSET = $clog2(TSETTLE + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DECIDE,
        DONE
    } cal_state_t;

    typedef logic signed [NBIT-1:0]  tdc_code_t;
    typedef logic signed [NSUM-1:0]  tdc_sum_t;
    typedef logic        [NTRIM-1:0] trim_t;

    localparam trim_t    TRIM_MID   = trim_t'(1 << (NTRIM - 1));
    // Sum of 2^NAVG_LOG2 samples equal to TARGET, full signed precision.
    localparam tdc_sum_t SUM_THRESH = tdc_sum_t'(TARGET * (2 ** NAVG_LOG2));

endpackage

// File: rtl/tdc_accum.sv
// Valid-qualified sample counter plus signed accumulator for one SAR step.
// Ports:
//   clk_ref, rstb : clock, async active-low reset
//   clr           : zero the accumulator and sample counter
//   en            : accumulate enable (FSM in ACCUM)
//   valid, code   : TDC sample and its qualifier
//   acc           : running signed sum of the step
//   last_c        : combinational; this accepted sample completes the step
module tdc_accum
    import tdc_pkg::*;
(
    input  logic      clk_ref,
    input  logic      rstb,
    input  logic      clr,
    input  logic      en,
    input  logic      valid,
    input  tdc_code_t code,
    output tdc_sum_t  acc,
    output logic      last_c
);

    logic [NAVG_LOG2-1:0] cnt;

    assign last_c = en && valid && (cnt == '1);

    // Sum width covers 2^NAVG_LOG2 worst-case codes, so no overflow guard.
    always_ff @(posedge clk_ref or negedge rstb) begin
        if (!rstb) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en && valid) begin
            acc <= acc + tdc_sum_t'(code);
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdc_cal_ctrl.sv
// TDC gain-calibration sequencer: SAR search over the delay-line trim code,
// averaging TDC codes per step, with a combinational manual-override mux.
// Ports:
//   clk_ref, rstb         : reference clock, async active-low reset
//   start                 : single-cycle calibration request (IDLE only)
//   tdc_code, tdc_valid   : signed TDC sample and qualifier
//   trim_ovr, trim_ovr_val: manual trim override (output mux only)
//   cal_en                : selects calibration stimulus at the TDC input
//   trim                  : delay-line trim code (override or SAR register)
//   busy, done            : calibration running / completed since last start
//   sum_out               : accumulated sum of the last decided step
module tdc_cal_ctrl
    import tdc_pkg::*;
(
    input  logic                   clk_ref,
    input  logic                   rstb,
    input  logic                   start,
    input  logic signed [NBIT-1:0] tdc_code,
    input  logic                   tdc_valid,
    input  logic                   trim_ovr,
    input  logic [NTRIM-1:0]       trim_ovr_val,
    output logic                   cal_en,
    output logic [NTRIM-1:0]       trim,
    output logic                   busy,
    output logic                   done,
    output logic signed [NSUM-1:0] sum_out
);

    localparam logic [NIDX-1:0] IDX_MSB  = NIDX'(NTRIM - 1);
    localparam logic [NSET-1:0] SET_LAST = NSET'(TSETTLE - 1);

    cal_state_t      state_q, state_d;
    trim_t           trim_q, trim_d;
    logic [NIDX-1:0] idx_q, idx_d;
    logic [NSET-1:0] set_cnt_q, set_cnt_d;
    logic            busy_d, cal_en_d, done_d;
    tdc_sum_t        sum_d;
    tdc_sum_t        acc;
    logic            acc_clr_c, acc_en_c, acc_last_c;
    trim_t           bit_mask, next_mask;
    logic            keep;

    assign acc_en_c = (state_q == ACCUM);

    tdc_accum u_accum (
        .clk_ref (clk_ref),
        .rstb    (rstb),
        .clr     (acc_clr_c),
        .en      (acc_en_c),
        .valid   (tdc_valid),
        .code    (tdc_code),
        .acc     (acc),
        .last_c  (acc_last_c)
    );

    // Override only steers the output; the search register is untouched.
    assign trim = trim_ovr ? trim_ovr_val : trim_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        trim_d    = trim_q;
        idx_d     = idx_q;
        set_cnt_d = set_cnt_q;
        busy_d    = busy;
        cal_en_d  = cal_en;
        done_d    = done;
        sum_d     = sum_out;
        acc_clr_c = 1'b0;
        bit_mask  = trim_t'(1) << idx_q;
        next_mask = (idx_q != '0) ? (bit_mask >> 1) : '0;
        // Code falls as trim rises: keep the bit while still above target.
        keep      = (acc > SUM_THRESH);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETTLE;
                    idx_d     = IDX_MSB;
                    trim_d    = TRIM_MID;
                    set_cnt_d = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    cal_en_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    acc_clr_c = 1'b1;
                    state_d   = ACCUM;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ACCUM: begin
                if (acc_last_c) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                sum_d  = acc;
                trim_d = (keep ? trim_q : (trim_q & ~bit_mask)) | next_mask;
                if (idx_q != '0) begin
                    idx_d     = idx_q - 1'b1;
                    set_cnt_d = '0;
                    state_d   = SETTLE;
                end else begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cal_en_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_ref or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            trim_q    <= TRIM_MID;
            idx_q     <= '0;
            set_cnt_q <= '0;
            busy      <= 1'b0;
            cal_en    <= 1'b0;
            done      <= 1'b0;
            sum_out   <= '0;
        end else begin
            state_q   <= state_d;
            trim_q    <= trim_d;
            idx_q     <= idx_d;
            set_cnt_q <= set_cnt_d;
            busy      <= busy_d;
            cal_en    <= cal_en_d;
            done      <= done_d;
            sum_out   <= sum_d;
        end
    end

endmodule

// File: tb/tb_tdc_cal_ctrl.sv
module tb_tdc_cal_ctrl;

    logic              clk_ref = 1'b0;
    logic              rstb;
    logic              start;
    logic signed [3:0] tdc_code;
    logic              tdc_valid;
    logic              trim_ovr;
    logic [5:0]        trim_ovr_val;
    logic              cal_en;
    logic [5:0]        trim;
    logic              busy;
    logic              done;
    logic signed [7:0] sum_out;

    int checks   = 0;
    int failures = 0;

    // Stimulus configuration: 0 = model from DUT trim, 1 = constant, 2 = model from schedule.
    int code_mode  = 0;
    int const_code = 0;
    int vmode      = 0;
    int sched [6]  = '{32, 16, 24, 20, 18, 19};

    // Observations from the last run.
    int         done_at;
    logic [5:0] obs_trim [6];
    bit         calen_ok;
    bit         busy_ok;

    always #5 clk_ref = ~clk_ref;

    tdc_cal_ctrl dut (
        .clk_ref      (clk_ref),
        .rstb         (rstb),
        .start        (start),
        .tdc_code     (tdc_code),
        .tdc_valid    (tdc_valid),
        .trim_ovr     (trim_ovr),
        .trim_ovr_val (trim_ovr_val),
        .cal_en       (cal_en),
        .trim         (trim),
        .busy         (busy),
        .done         (done),
        .sum_out      (sum_out)
    );

    function automatic int model_code(input int tr);
        int v;
        v = 20 - tr;
        if (v < -8) v = -8;
        if (v > 7)  v = 7;
        return v;
    endfunction

    // Drive TDC inputs for cycle t of a run (t counts cycles after the start edge).
    task automatic drive(input int t, input int win);
        int k;
        int c;
        k = (t < 0) ? 0 : t / win;
        if (k > 5) k = 5;
        case (code_mode)
            0:       c = model_code(int'(trim));
            1:       c = const_code;
            default: c = model_code(sched[k]);
        endcase
        tdc_code  = 4'(c);
        tdc_valid = (vmode == 0) ? 1'b1 : (t >= 0 && ((t % win) % 2) == 1);
    endtask

    // Pulse start, then advance one cycle at a time until done, abort_t or a cycle budget.
    task automatic run_cal(input int win, input int xstart_t, input int ovr_t, input int abort_t);
        done_at  = -1;
        calen_ok = 1'b1;
        busy_ok  = 1'b1;
        for (int k = 0; k < 6; k++) obs_trim[k] = 6'h3f;
        @(negedge clk_ref);
        start = 1'b1;
        drive(-1, win);
        @(negedge clk_ref);
        start = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (t == abort_t) return;
            if ((t % win) == 0 && (t / win) < 6) obs_trim[t / win] = trim;
            if (done === 1'b1) begin
                done_at = t;
                break;
            end
            if (cal_en !== 1'b1) calen_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (t == xstart_t);
            if (t == ovr_t) begin
                trim_ovr     = 1'b1;
                trim_ovr_val = 6'd5;
            end
            drive(t, win);
            @(negedge clk_ref);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0; start = 1'b0; tdc_code = '0; tdc_valid = 1'b0;
        trim_ovr = 1'b1; trim_ovr_val = 6'd9;
        repeat (3) @(negedge clk_ref);
        checks++; if (trim !== 6'd9) begin failures++; $display("FAIL reset_ovr_trim: got %0d expected 9", trim); end
        trim_ovr = 1'b0;
        #1;
        checks++; if (trim !== 6'd32) begin failures++; $display("FAIL reset_trim: got %0d expected 32", trim); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (cal_en !== 1'b0) begin failures++; $display("FAIL reset_cal_en: got %b expected 0", cal_en); end
        checks++; if (sum_out !== 8'sd0) begin failures++; $display("FAIL reset_sum_out: got %0d expected 0", sum_out); end
        @(negedge clk_ref);
        rstb = 1'b1;
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic test_sar_sweep();
        code_mode = 0; vmode = 0;
        run_cal(25, -1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (int'(obs_trim[k]) !== sched[k]) begin failures++; $display("FAIL sweep_trim_step%0d: got %0d expected %0d", k, obs_trim[k], sched[k]); end
        end
        checks++; if (done_at !== 150) begin failures++; $display("FAIL sweep_done_latency: got %0d expected 150", done_at); end
        checks++; if (calen_ok !== 1'b1) begin failures++; $display("FAIL sweep_cal_en_high: got %b expected 1", calen_ok); end
        checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL sweep_busy_high: got %b expected 1", busy_ok); end
        checks++; if (trim !== 6'd19) begin failures++; $display("FAIL sweep_final_trim: got %0d expected 19", trim); end
        checks++; if (int'(sum_out) !== 16) begin failures++; $display("FAIL sweep_sum_out: got %0d expected 16", sum_out); end
        checks++; if (busy !== 1'b0 || cal_en !== 1'b0) begin failures++; $display("FAIL sweep_done_flags: got busy=%b cal_en=%b expected 0 0", busy, cal_en); end
        repeat (3) @(negedge clk_ref);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL sweep_done_held: got %b expected 1", done); end
    endtask

    task automatic test_saturation();
        code_mode = 1; vmode = 0; const_code = -3;
        run_cal(25, -1, -1, -1);
        checks++; if (done_at !== 150) begin failures++; $display("FAIL neg_done_latency: got %0d expected 150", done_at); end
        checks++; if (trim !== 6'd0) begin failures++; $display("FAIL neg_final_trim: got %0d expected 0", trim); end
        checks++; if (int'(sum_out) !== -48) begin failures++; $display("FAIL neg_sum_out: got %0d expected -48", sum_out); end
        repeat (2) @(negedge clk_ref);
        const_code = 5;
        run_cal(25, -1, -1, -1);
        checks++; if (trim !== 6'd63) begin failures++; $display("FAIL pos_final_trim: got %0d expected 63", trim); end
        checks++; if (int'(sum_out) !== 80) begin failures++; $display("FAIL pos_sum_out: got %0d expected 80", sum_out); end
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic test_valid_gaps();
        code_mode = 0; vmode = 1;
        run_cal(41, -1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (int'(obs_trim[k]) !== sched[k]) begin failures++; $display("FAIL gaps_trim_step%0d: got %0d expected %0d", k, obs_trim[k], sched[k]); end
        end
        checks++; if (done_at !== 246) begin failures++; $display("FAIL gaps_done_latency: got %0d expected 246", done_at); end
        checks++; if (trim !== 6'd19) begin failures++; $display("FAIL gaps_final_trim: got %0d expected 19", trim); end
        vmode = 0;
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic test_reset_abort();
        code_mode = 0; vmode = 0;
        run_cal(25, -1, -1, 52);
        checks++; if (trim !== 6'd24) begin failures++; $display("FAIL abort_pre_trim: got %0d expected 24", trim); end
        rstb = 1'b0;
        #1;
        checks++; if (trim !== 6'd32) begin failures++; $display("FAIL abort_trim: got %0d expected 32", trim); end
        checks++; if (busy !== 1'b0 || cal_en !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%b cal_en=%b done=%b expected 0 0 0", busy, cal_en, done); end
        checks++; if (sum_out !== 8'sd0) begin failures++; $display("FAIL abort_sum_out: got %0d expected 0", sum_out); end
        @(negedge clk_ref);
        rstb = 1'b1;
        repeat (2) @(negedge clk_ref);
        run_cal(25, -1, -1, -1);
        checks++; if (done_at !== 150) begin failures++; $display("FAIL abort_rerun_latency: got %0d expected 150", done_at); end
        checks++; if (trim !== 6'd19) begin failures++; $display("FAIL abort_rerun_trim: got %0d expected 19", trim); end
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic test_back_to_back();
        code_mode = 0; vmode = 0;
        repeat (9) @(negedge clk_ref);
        run_cal(25, 49, -1, -1);
        checks++; if (done_at !== 150) begin failures++; $display("FAIL b2b_done_latency: got %0d expected 150", done_at); end
        checks++; if (trim !== 6'd19) begin failures++; $display("FAIL b2b_final_trim: got %0d expected 19", trim); end
        // Start during the DONE cycle is not accepted.
        start = 1'b1;
        @(negedge clk_ref);
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL b2b_start_in_done: got busy=%b done=%b expected 0 1", busy, done); end
        // Start in IDLE is accepted.
        start = 1'b1;
        @(negedge clk_ref);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || cal_en !== 1'b1) begin failures++; $display("FAIL b2b_restart_flags: got busy=%b done=%b cal_en=%b expected 1 0 1", busy, done, cal_en); end
        checks++; if (trim !== 6'd32) begin failures++; $display("FAIL b2b_restart_trim: got %0d expected 32", trim); end
        rstb = 1'b0;
        @(negedge clk_ref);
        rstb = 1'b1;
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic test_override();
        code_mode = 2; vmode = 0;
        run_cal(25, -1, 30, -1);
        checks++; if (obs_trim[1] !== 6'd16) begin failures++; $display("FAIL ovr_pre_trim: got %0d expected 16", obs_trim[1]); end
        checks++; if (obs_trim[2] !== 6'd5) begin failures++; $display("FAIL ovr_active_trim: got %0d expected 5", obs_trim[2]); end
        checks++; if (done_at !== 150) begin failures++; $display("FAIL ovr_done_latency: got %0d expected 150", done_at); end
        checks++; if (trim !== 6'd5) begin failures++; $display("FAIL ovr_final_out: got %0d expected 5", trim); end
        checks++; if (int'(sum_out) !== 16) begin failures++; $display("FAIL ovr_sum_out: got %0d expected 16", sum_out); end
        trim_ovr = 1'b0;
        #1;
        checks++; if (trim !== 6'd19) begin failures++; $display("FAIL ovr_release_trim: got %0d expected 19", trim); end
        repeat (2) @(negedge clk_ref);
    endtask

    initial begin
        test_reset();
        test_sar_sweep();
        test_saturation();
        test_valid_gaps();
        test_reset_abort();
        test_back_to_back();
        test_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
